// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions for the EX multiply/divide path: operand width,
// mul/div op encodings and the iterative unit's FSM states.
package cpu_defs;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and emit one quotient bit.
module ex_div_iter #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // Remainder stays below divisor, so diff[W] is exactly the borrow.
  always_comb begin
    shifted = {rem_in, quo_in[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[W]) begin
      rem_out = diff[W-1:0];
      quo_out = {quo_in[W-2:0], 1'b1};
    end else begin
      rem_out = shifted[W-1:0];
      quo_out = {quo_in[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit in EX: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up applied in DONE.
module ex_muldiv_unit
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W = cpu_defs::DATA_W,
  parameter int unsigned CNT_W  = cpu_defs::CNT_W
) (
  input  logic                clk,
  input  logic                rset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [DATA_W-1:0]   value_A_in,
  input  logic [DATA_W-1:0]   value_B_in,
  input  logic                flush,
  output logic                stall,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] HILO_out,
  output logic                div_by_zero
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*DATA_W-1:0]   acc_q;     // product, or {remainder, quotient} for divide
  logic [2*DATA_W-1:0]   mcand_q;
  logic [DATA_W-1:0]     mplier_q;  // multiplier, or divisor for divide
  logic                  div_q, signed_q, sa_q, sb_q, dbz_q;
  logic [2*DATA_W-1:0]   hilo_q;
  logic                  dbz_flag_q;

  logic                  accept;
  logic                  in_signed, in_div, in_dbz;
  logic [DATA_W-1:0]     a_mag, b_mag;
  logic [DATA_W-1:0]     rem_nx, quo_nx;
  logic [DATA_W-1:0]     q_fix, r_fix;
  logic [2*DATA_W-1:0]   result;

  ex_div_iter #(.W(DATA_W)) u_div_iter (
    .rem_in  (acc_q[2*DATA_W-1:DATA_W]),
    .quo_in  (acc_q[DATA_W-1:0]),
    .divisor (mplier_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  always_comb begin
    in_signed = op_is_signed(op);
    in_div    = op_is_div(op);
    in_dbz    = in_div && (value_B_in == '0);
    a_mag     = (in_signed && value_A_in[DATA_W-1]) ? -value_A_in : value_A_in;
    b_mag     = (in_signed && value_B_in[DATA_W-1]) ? -value_B_in : value_B_in;
    accept    = (state_q == ST_IDLE) && start && !flush;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = in_dbz ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Divide-by-zero parks |A| in the remainder so the normal fix-up restores A.
  always_comb begin
    q_fix = acc_q[DATA_W-1:0];
    r_fix = acc_q[2*DATA_W-1:DATA_W];
    if (dbz_q)                  q_fix = '1;
    else if (signed_q && (sa_q ^ sb_q)) q_fix = -acc_q[DATA_W-1:0];
    if (signed_q && sa_q)       r_fix = -acc_q[2*DATA_W-1:DATA_W];
    if (div_q)                  result = {r_fix, q_fix};
    else if (signed_q && (sa_q ^ sb_q)) result = -acc_q;
    else                        result = acc_q;
  end

  always_comb begin
    busy        = (state_q == ST_CALC);
    done        = (state_q == ST_DONE) && !flush;
    HILO_out    = done ? result : hilo_q;
    div_by_zero = dbz_flag_q;
    stall       = !(rset && !flush && (accept || (state_q == ST_CALC)));
  end

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      div_q      <= 1'b0;
      signed_q   <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dbz_q      <= 1'b0;
      hilo_q     <= '0;
      dbz_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!flush) begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              cnt_q      <= '0;
              div_q      <= in_div;
              signed_q   <= in_signed;
              sa_q       <= value_A_in[DATA_W-1];
              sb_q       <= value_B_in[DATA_W-1];
              dbz_q      <= in_dbz;
              dbz_flag_q <= in_dbz;
              mplier_q   <= b_mag;
              mcand_q    <= {{DATA_W{1'b0}}, a_mag};
              if (!in_div)     acc_q <= '0;
              else if (in_dbz) acc_q <= {a_mag, {DATA_W{1'b0}}};
              else             acc_q <= {{DATA_W{1'b0}}, a_mag};
            end
          end
          ST_CALC: begin
            cnt_q <= cnt_q + 1'b1;
            if (div_q) begin
              acc_q <= {rem_nx, quo_nx};
            end else begin
              if (mplier_q[0]) acc_q <= acc_q + mcand_q;
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
            end
          end
          ST_DONE: hilo_q <= result;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: latency, stall handshake,
// signed/unsigned results, divide-by-zero, flush and asynchronous reset.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] value_A_in;
  logic [31:0] value_B_in;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [63:0] HILO_out;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rset        (rset),
    .start       (start),
    .op          (op),
    .value_A_in  (value_A_in),
    .value_B_in  (value_B_in),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .HILO_out    (HILO_out),
    .div_by_zero (div_by_zero)
  );

  // Issues one op; returns cycles from T until done (0 if none within 40)
  // and the number of cycles in T..done-1 where stall was not low.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stall_bad);
    stall_bad = 0;
    lat       = 0;
    @(negedge clk);
    op = o; value_A_in = a; value_B_in = b; start = 1'b1;
    #1 if (stall !== 1'b0) stall_bad++;
    @(posedge clk);
    #1 start = 1'b0; value_A_in = 32'h5A5A_5A5A; value_B_in = 32'h0000_0003;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (stall !== 1'b0) stall_bad++;
    end
  endtask

  task automatic test_reset;
    rset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
    value_A_in = '0; value_B_in = '0;
    #12;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got=%b exp=1", stall); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (HILO_out !== 64'h0) begin n_fail++; $display("FAIL reset_hilo got=%h exp=0", HILO_out); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk); rset = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL idle_stall got=%b exp=1", stall); end
  endtask

  task automatic test_multu;
    int lat, sb;
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, lat, sb);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL multu_latency got=%0d exp=33", lat); end
    n_checks++; if (sb != 0) begin n_fail++; $display("FAIL multu_stall_low got=%0d bad cycles exp=0", sb); end
    n_checks++; if (HILO_out !== 64'h0000_0001_FFFF_FFFE) begin n_fail++; $display("FAIL multu_hilo got=%h exp=00000001fffffffe", HILO_out); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL multu_done_stall got=%b exp=1", stall); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_done_busy got=%b exp=0", busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
    n_checks++; if (HILO_out !== 64'h0000_0001_FFFF_FFFE) begin n_fail++; $display("FAIL multu_hilo_held got=%h exp=00000001fffffffe", HILO_out); end
  endtask

  task automatic test_mult;
    int lat, sb;
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, lat, sb);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    n_checks++; if (HILO_out !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_neg got=%h exp=ffffffffffffffeb", HILO_out); end
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, sb);
    n_checks++; if (HILO_out !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL mult_minmin got=%h exp=4000000000000000", HILO_out); end
  endtask

  task automatic test_div;
    int lat, sb;
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, sb);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL div_latency got=%0d exp=33", lat); end
    n_checks++; if (sb != 0) begin n_fail++; $display("FAIL div_stall_low got=%0d bad cycles exp=0", sb); end
    n_checks++; if (HILO_out !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg got=%h exp=fffffffffffffffd", HILO_out); end
    run_op(2'b11, 32'd100, 32'd7, lat, sb);
    n_checks++; if (HILO_out !== 64'h0000_0002_0000_000E) begin n_fail++; $display("FAIL divu_100_7 got=%h exp=000000020000000e", HILO_out); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, sb);
    n_checks++; if (HILO_out !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_overflow got=%h exp=0000000080000000", HILO_out); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div_overflow_flag got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_div_by_zero;
    int lat, sb;
    run_op(2'b11, 32'd5, 32'd0, lat, sb);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    n_checks++; if (HILO_out !== 64'h0000_0005_FFFF_FFFF) begin n_fail++; $display("FAIL dbz_hilo got=%h exp=00000005ffffffff", HILO_out); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, lat, sb);
    n_checks++; if (HILO_out !== 64'hFFFF_FFFB_FFFF_FFFF) begin n_fail++; $display("FAIL dbz_signed_hilo got=%h exp=fffffffbffffffff", HILO_out); end
    repeat (3) @(negedge clk);
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_sticky got=%b exp=1", div_by_zero); end
  endtask

  task automatic test_flush;
    int seen_done = 0;
    @(negedge clk);
    op = 2'b10; value_A_in = 32'd100; value_B_in = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL start_clears_dbz got=%b exp=0", div_by_zero); end
    flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall got=%b exp=1", stall); end
    @(posedge clk);
    #1 flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_idle_stall got=%b exp=1", stall); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL flush_no_done got=%0d pulses exp=0", seen_done); end
    n_checks++; if (HILO_out !== 64'hFFFF_FFFB_FFFF_FFFF) begin n_fail++; $display("FAIL flush_hilo_kept got=%h exp=fffffffbffffffff", HILO_out); end

    seen_done = 0;
    @(negedge clk);
    op = 2'b01; value_A_in = 32'd3; value_B_in = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_start_stall got=%b exp=1", stall); end
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_rejected got=%b exp=0", busy); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL flush_start_no_done got=%0d pulses exp=0", seen_done); end
  endtask

  task automatic test_reset_mid_op;
    int lat, sb;
    run_op(2'b11, 32'd9, 32'd0, lat, sb);
    @(negedge clk);
    op = 2'b00; value_A_in = 32'hFFFF_FFFD; value_B_in = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_busy got=%b exp=1", busy); end
    rset = 1'b0;
    #1;
    n_checks++; if (HILO_out !== 64'h0) begin n_fail++; $display("FAIL rmid_hilo got=%h exp=0", HILO_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rmid_stall got=%b exp=1", stall); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rmid_dbz got=%b exp=0", div_by_zero); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got=%b exp=0", done); end
    @(negedge clk); rset = 1'b1;
    run_op(2'b01, 32'd6, 32'd7, lat, sb);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL post_reset_latency got=%0d exp=33", lat); end
    n_checks++; if (HILO_out !== 64'd42) begin n_fail++; $display("FAIL post_reset_hilo got=%h exp=000000000000002a", HILO_out); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_div_by_zero;
    test_flush;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
